// File: rtl/irb_pkg.sv
// Shared types and default constants for the controller-to-DMA command path.
// Region bases and per-command lengths are defaults for dma_cmd_engine parameters.
package irb_pkg;

    typedef enum logic [2:0] {
        OP_INF = 3'd0,
        OP_FMI = 3'd1,
        OP_KEX = 3'd2,
        OP_KPW = 3'd3,
        OP_KDW = 3'd4,
        OP_FMO = 3'd5
    } dma_op_t;

    typedef enum logic [2:0] {
        S_IDLE,
        S_SETUP,
        S_RD_BUF,
        S_RD_LAT,
        S_REQ,
        S_WAIT_R,
        S_DONE
    } dma_state_t;

    localparam logic [31:0] DMA_INF_BASE = 32'h0000_0000;
    localparam logic [31:0] DMA_FMI_BASE = 32'h0001_0000;
    localparam logic [31:0] DMA_KEX_BASE = 32'h0002_0000;
    localparam logic [31:0] DMA_KPW_BASE = 32'h0003_0000;
    localparam logic [31:0] DMA_KDW_BASE = 32'h0004_0000;
    localparam logic [31:0] DMA_FMO_BASE = 32'h0008_0000;

    localparam int unsigned DMA_TI_ROWS = 4;
    localparam int unsigned DMA_TI_COLS = 4;
    localparam int unsigned DMA_TO_ROWS = 2;
    localparam int unsigned DMA_TO_COLS = 2;
    localparam int unsigned DMA_KEX_LEN = 8;
    localparam int unsigned DMA_KPW_LEN = 8;
    localparam int unsigned DMA_KDW_LEN = 9;
    localparam int unsigned DMA_CNT_W   = 16;

    function automatic logic is_legal_op(input logic [2:0] op);
        return op <= 3'(OP_FMO);
    endfunction

endpackage

// File: rtl/dma_addr_gen.sv
// Row/column walker for DMA bursts: produces word address, beat index and last flag.
// Row base is accumulated by stride on each row wrap, so no multiplier is needed.
module dma_addr_gen
    import irb_pkg::*;
#(
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned CNT_W  = DMA_CNT_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_init,
    input  logic              i_step,
    input  logic [CNT_W-1:0]  i_rows,
    input  logic [CNT_W-1:0]  i_cols,
    input  logic [ADDR_W-1:0] i_stride,
    input  logic [ADDR_W-1:0] i_base,
    output logic [ADDR_W-1:0] o_addr,
    output logic [CNT_W-1:0]  o_beat,
    output logic              o_last
);

    logic [CNT_W-1:0]  r_row;
    logic [CNT_W-1:0]  r_col;
    logic [CNT_W-1:0]  r_beat;
    logic [ADDR_W-1:0] r_row_base;
    logic              w_col_wrap;

    assign w_col_wrap = (r_col == i_cols - 1'b1);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_row      <= '0;
            r_col      <= '0;
            r_beat     <= '0;
            r_row_base <= '0;
        end else if (i_init) begin
            r_row      <= '0;
            r_col      <= '0;
            r_beat     <= '0;
            r_row_base <= i_base;
        end else if (i_step) begin
            r_beat <= r_beat + 1'b1;
            if (w_col_wrap) begin
                r_col      <= '0;
                r_row      <= r_row + 1'b1;
                r_row_base <= r_row_base + i_stride;
            end else begin
                r_col <= r_col + 1'b1;
            end
        end
    end

    assign o_addr = r_row_base + ADDR_W'(r_col);
    assign o_beat = r_beat;
    assign o_last = (r_row == i_rows - 1'b1) && w_col_wrap;

endmodule

// File: rtl/dma_cmd_engine.sv
// Responder side of the controller-to-DMA command interface: runs one command as a
// sequence of single-word memory transactions, loading buffers or draining the output tile.
module dma_cmd_engine
    import irb_pkg::*;
#(
    parameter int unsigned       ADDR_W   = 32,
    parameter logic [ADDR_W-1:0] INF_BASE = ADDR_W'(DMA_INF_BASE),
    parameter logic [ADDR_W-1:0] FMI_BASE = ADDR_W'(DMA_FMI_BASE),
    parameter logic [ADDR_W-1:0] KEX_BASE = ADDR_W'(DMA_KEX_BASE),
    parameter logic [ADDR_W-1:0] KPW_BASE = ADDR_W'(DMA_KPW_BASE),
    parameter logic [ADDR_W-1:0] KDW_BASE = ADDR_W'(DMA_KDW_BASE),
    parameter logic [ADDR_W-1:0] FMO_BASE = ADDR_W'(DMA_FMO_BASE),
    parameter int unsigned       TI_ROWS  = DMA_TI_ROWS,
    parameter int unsigned       TI_COLS  = DMA_TI_COLS,
    parameter int unsigned       TO_ROWS  = DMA_TO_ROWS,
    parameter int unsigned       TO_COLS  = DMA_TO_COLS,
    parameter int unsigned       KEX_LEN  = DMA_KEX_LEN,
    parameter int unsigned       KPW_LEN  = DMA_KPW_LEN,
    parameter int unsigned       KDW_LEN  = DMA_KDW_LEN
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              s_dma,
    input  logic [2:0]        dma_op,
    input  logic [31:0]       dma_info1,
    input  logic [31:0]       dma_info2,
    input  logic [31:0]       dma_mem_info1,
    input  logic [31:0]       dma_mem_info2,
    output logic              f_dma,
    output logic              cmd_err,
    output logic [63:0]       inf_conv,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    input  logic              mem_gnt,
    input  logic              mem_rvalid,
    input  logic [31:0]       mem_rdata,
    output logic              buf_wr_en,
    output logic [2:0]        buf_sel,
    output logic [15:0]       buf_addr,
    output logic [31:0]       buf_wdata,
    output logic              obuf_rd_en,
    output logic [15:0]       obuf_addr,
    input  logic [31:0]       obuf_rdata,
    output logic [63:0]       cmd_info
);

    localparam int unsigned CNT_W = DMA_CNT_W;

    dma_state_t r_state;
    logic [2:0]  r_op;
    logic [31:0] r_info1;
    logic [31:0] r_info2;
    logic [31:0] r_mem_info1;
    logic [31:0] r_mem_info2;
    logic [63:0] r_inf_conv;
    logic        r_f_dma;
    logic        r_cmd_err;
    logic        r_mem_req;
    logic        r_mem_we;
    logic [31:0] r_mem_wdata;
    logic        r_buf_wr_en;
    logic [15:0] r_buf_addr;
    logic [31:0] r_buf_wdata;
    logic        r_obuf_rd_en;

    logic [ADDR_W-1:0] w_region;
    logic [ADDR_W-1:0] w_base;
    logic [ADDR_W-1:0] w_stride;
    logic [ADDR_W-1:0] w_addr;
    logic [CNT_W-1:0]  w_rows;
    logic [CNT_W-1:0]  w_cols;
    logic [CNT_W-1:0]  w_beat;
    logic              w_last;
    logic              w_init;
    logic              w_step;

    // Geometry depends only on latched op and inf_conv, so it is stable for the whole command.
    always_comb begin
        w_region = INF_BASE;
        w_rows   = CNT_W'(1);
        w_cols   = CNT_W'(2);
        w_stride = '0;
        case (r_op)
            OP_FMI: begin
                w_region = FMI_BASE;
                w_rows   = CNT_W'(TI_ROWS);
                w_cols   = CNT_W'(TI_COLS);
                w_stride = ADDR_W'(r_inf_conv[7:0]);
            end
            OP_KEX: begin
                w_region = KEX_BASE;
                w_cols   = CNT_W'(KEX_LEN);
            end
            OP_KPW: begin
                w_region = KPW_BASE;
                w_cols   = CNT_W'(KPW_LEN);
            end
            OP_KDW: begin
                w_region = KDW_BASE;
                w_cols   = CNT_W'(KDW_LEN);
            end
            OP_FMO: begin
                w_region = FMO_BASE;
                w_rows   = CNT_W'(TO_ROWS);
                w_cols   = CNT_W'(TO_COLS);
                w_stride = ADDR_W'(r_inf_conv[7:0] >> r_inf_conv[41]);
            end
            default: ;
        endcase
    end

    assign w_base = w_region + ADDR_W'(r_mem_info2) + ADDR_W'(r_mem_info1);
    assign w_init = (r_state == S_SETUP);
    // Reads advance on returned data, writes advance on grant.
    assign w_step = ((r_state == S_WAIT_R) && mem_rvalid)
                 || ((r_state == S_REQ) && mem_gnt && r_mem_we);

    dma_addr_gen #(
        .ADDR_W (ADDR_W),
        .CNT_W  (CNT_W)
    ) u_addr_gen (
        .clk      (clk),
        .rst      (rst),
        .i_init   (w_init),
        .i_step   (w_step),
        .i_rows   (w_rows),
        .i_cols   (w_cols),
        .i_stride (w_stride),
        .i_base   (w_base),
        .o_addr   (w_addr),
        .o_beat   (w_beat),
        .o_last   (w_last)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state      <= S_IDLE;
            r_op         <= '0;
            r_info1      <= '0;
            r_info2      <= '0;
            r_mem_info1  <= '0;
            r_mem_info2  <= '0;
            r_inf_conv   <= '0;
            r_f_dma      <= 1'b0;
            r_cmd_err    <= 1'b0;
            r_mem_req    <= 1'b0;
            r_mem_we     <= 1'b0;
            r_mem_wdata  <= '0;
            r_buf_wr_en  <= 1'b0;
            r_buf_addr   <= '0;
            r_buf_wdata  <= '0;
            r_obuf_rd_en <= 1'b0;
        end else begin
            r_f_dma     <= 1'b0;
            r_buf_wr_en <= 1'b0;
            if (s_dma && (r_state != S_IDLE)) begin
                r_cmd_err <= 1'b1;
            end
            case (r_state)
                S_IDLE: begin
                    if (s_dma) begin
                        r_op        <= dma_op;
                        r_info1     <= dma_info1;
                        r_info2     <= dma_info2;
                        r_mem_info1 <= dma_mem_info1;
                        r_mem_info2 <= dma_mem_info2;
                        if (is_legal_op(dma_op)) begin
                            r_state <= S_SETUP;
                        end else begin
                            r_cmd_err <= 1'b1;
                            r_f_dma   <= 1'b1;
                            r_state   <= S_DONE;
                        end
                    end
                end
                S_SETUP: begin
                    if (r_op == OP_FMO) begin
                        r_obuf_rd_en <= 1'b1;
                        r_state      <= S_RD_BUF;
                    end else begin
                        r_mem_req <= 1'b1;
                        r_mem_we  <= 1'b0;
                        r_state   <= S_REQ;
                    end
                end
                S_RD_BUF: begin
                    r_obuf_rd_en <= 1'b0;
                    r_state      <= S_RD_LAT;
                end
                S_RD_LAT: begin
                    r_mem_wdata <= obuf_rdata;
                    r_mem_req   <= 1'b1;
                    r_mem_we    <= 1'b1;
                    r_state     <= S_REQ;
                end
                S_REQ: begin
                    if (mem_gnt) begin
                        r_mem_req <= 1'b0;
                        r_mem_we  <= 1'b0;
                        if (!r_mem_we) begin
                            r_state <= S_WAIT_R;
                        end else if (w_last) begin
                            r_f_dma <= 1'b1;
                            r_state <= S_DONE;
                        end else begin
                            r_obuf_rd_en <= 1'b1;
                            r_state      <= S_RD_BUF;
                        end
                    end
                end
                S_WAIT_R: begin
                    if (mem_rvalid) begin
                        if (r_op == OP_INF) begin
                            if (w_beat == '0) r_inf_conv[31:0]  <= mem_rdata;
                            else              r_inf_conv[63:32] <= mem_rdata;
                        end else begin
                            r_buf_wr_en <= 1'b1;
                            r_buf_addr  <= w_beat[15:0];
                            r_buf_wdata <= mem_rdata;
                        end
                        if (w_last) begin
                            r_f_dma <= 1'b1;
                            r_state <= S_DONE;
                        end else begin
                            r_mem_req <= 1'b1;
                            r_state   <= S_REQ;
                        end
                    end
                end
                S_DONE: begin
                    r_state <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign f_dma      = r_f_dma;
    assign cmd_err    = r_cmd_err;
    assign inf_conv   = r_inf_conv;
    assign mem_req    = r_mem_req;
    assign mem_we     = r_mem_we;
    assign mem_addr   = w_addr;
    assign mem_wdata  = r_mem_wdata;
    assign buf_wr_en  = r_buf_wr_en;
    assign buf_sel    = r_op;
    assign buf_addr   = r_buf_addr;
    assign buf_wdata  = r_buf_wdata;
    assign obuf_rd_en = r_obuf_rd_en;
    assign obuf_addr  = w_beat[15:0];
    assign cmd_info   = {r_info2, r_info1};

endmodule

// File: tb/tb_dma_cmd_engine.sv
// Bench for dma_cmd_engine: directed commands against a transaction-level model
// (expected request/buffer-write queues, latency and register values per command).
module tb_dma_cmd_engine;

    logic        clk = 1'b0;
    logic        rst;
    logic        s_dma;
    logic [2:0]  dma_op;
    logic [31:0] dma_info1, dma_info2, dma_mem_info1, dma_mem_info2;
    logic        f_dma, cmd_err;
    logic [63:0] inf_conv, cmd_info;
    logic        mem_req, mem_we, mem_gnt, mem_rvalid;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;
    logic        buf_wr_en, obuf_rd_en;
    logic [2:0]  buf_sel;
    logic [15:0] buf_addr, obuf_addr;
    logic [31:0] buf_wdata, obuf_rdata;

    dma_cmd_engine dut (
        .clk(clk), .rst(rst), .s_dma(s_dma), .dma_op(dma_op),
        .dma_info1(dma_info1), .dma_info2(dma_info2),
        .dma_mem_info1(dma_mem_info1), .dma_mem_info2(dma_mem_info2),
        .f_dma(f_dma), .cmd_err(cmd_err), .inf_conv(inf_conv),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_gnt(mem_gnt), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
        .buf_wr_en(buf_wr_en), .buf_sel(buf_sel), .buf_addr(buf_addr), .buf_wdata(buf_wdata),
        .obuf_rd_en(obuf_rd_en), .obuf_addr(obuf_addr), .obuf_rdata(obuf_rdata),
        .cmd_info(cmd_info)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct { logic [31:0] addr; logic we; logic [31:0] wdata; } req_t;
    typedef struct { logic [2:0] sel; logic [15:0] addr; logic [31:0] data; } bw_t;

    req_t        exp_req[$];
    bw_t         exp_buf[$];
    logic [31:0] seen_addr[$];
    logic [31:0] seen_wdata[$];
    logic [63:0] m_inf = '0, pend_inf = '0, m_info = '0;
    logic        m_err = 1'b0, f_pending = 1'b0;
    int          exp_lat = 0, s_edge = 0, last_lat = -1, done_cnt = 0, buf_cnt = 0;
    int          n_cmp = 0, n_bad = 0;
    logic [31:0] stall_addr = '0;
    int          stall_left = 0;
    logic        spur_rv = 1'b0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] want);
        n_cmp++;
        if (act !== want) begin
            n_bad++;
            $display("FAIL %s: got %0h want %0h (cycle %0d)", name, act, want, cyc);
        end
    endtask

    function automatic logic [31:0] mem_val(input logic [31:0] a);
        if (a == 32'h0) return 32'h0C08_1010;
        if (a == 32'h1) return 32'h0000_0240;
        return {a[15:0], ~a[15:0]};
    endfunction

    // Behavioural model: whole-command expectations from region, geometry and latency rules.
    task automatic build(input logic [2:0] op, input logic [31:0] m1, input logic [31:0] m2,
                         input int stalls);
        logic [31:0] base, stride, a;
        int rows, cols, n;
        req_t rq;
        bw_t  bw;
        rows = 1; cols = 0; stride = '0; base = '0;
        case (op)
            3'd0: cols = 2;
            3'd1: begin base = 32'h0001_0000; rows = 4; cols = 4; stride = 32'(m_inf[7:0]); end
            3'd2: begin base = 32'h0002_0000; cols = 8; end
            3'd3: begin base = 32'h0003_0000; cols = 8; end
            3'd4: begin base = 32'h0004_0000; cols = 9; end
            3'd5: begin base = 32'h0008_0000; rows = 2; cols = 2;
                        stride = 32'(m_inf[7:0]) >> m_inf[41]; end
            default: rows = 0;
        endcase
        base = base + m1 + m2;
        n = rows * cols;
        for (int r = 0; r < rows; r++) begin
            for (int c = 0; c < cols; c++) begin
                a = base + 32'(r) * stride + 32'(c);
                rq.addr = a; rq.we = (op == 3'd5); rq.wdata = 32'(100 + r * cols + c);
                exp_req.push_back(rq);
                if (op != 3'd0 && op != 3'd5) begin
                    bw.sel = op; bw.addr = 16'(r * cols + c); bw.data = mem_val(a);
                    exp_buf.push_back(bw);
                end
            end
        end
        if (op > 3'd5)       exp_lat = 1;
        else if (op == 3'd5) exp_lat = 3 * n + 2 + stalls;
        else                 exp_lat = 2 * n + 2 + stalls;
        if (op > 3'd5) m_err = 1'b1;
        pend_inf = (op == 3'd0) ? {mem_val(base + 32'd1), mem_val(base)} : m_inf;
    endtask

    task automatic issue(input logic [2:0] op, input logic [31:0] i1, input logic [31:0] i2,
                         input logic [31:0] m1, input logic [31:0] m2, input int stalls);
        @(posedge clk); #1;
        build(op, m1, m2, stalls);
        m_info = {i2, i1};
        seen_addr.delete(); seen_wdata.delete(); buf_cnt = 0;
        f_pending = 1'b1;
        s_edge = cyc + 1;
        dma_op = op; dma_info1 = i1; dma_info2 = i2; dma_mem_info1 = m1; dma_mem_info2 = m2;
        s_dma = 1'b1;
        @(posedge clk); #1;
        s_dma = 1'b0;
    endtask

    task automatic wait_done(input string name);
        int start;
        start = done_cnt;
        for (int i = 0; i < 400 && done_cnt == start; i++) begin
            @(negedge clk); #2;
        end
        chk({name, "_completed"}, 64'(done_cnt != start), 64'd1);
    endtask

    // Memory responder: grants (with optional stall), read data one cycle after grant.
    initial begin
        logic        acc, we;
        logic [31:0] a;
        mem_gnt = 1'b1; mem_rvalid = 1'b0; mem_rdata = '0;
        forever begin
            @(negedge clk);
            if (mem_req && mem_addr == stall_addr && stall_left > 0) begin
                mem_gnt = 1'b0; stall_left--;
            end else begin
                mem_gnt = 1'b1;
            end
            acc = mem_req && mem_gnt; we = mem_we; a = mem_addr;
            @(posedge clk); #1;
            mem_rvalid = (acc && !we) || spur_rv;
            mem_rdata  = (acc && !we) ? mem_val(a) : (spur_rv ? 32'h7777_7777 : 32'hBAD0_BAD0);
            spur_rv = 1'b0;
        end
    end

    // Output tile buffer: data = 100 + address, one cycle after the read strobe.
    initial begin
        logic        en;
        logic [15:0] a;
        obuf_rdata = '0;
        forever begin
            @(negedge clk);
            en = obuf_rd_en; a = obuf_addr;
            @(posedge clk); #1;
            obuf_rdata = en ? 32'(100 + 32'(a)) : 32'hDEAD_0000;
        end
    end

    // Compare process.
    initial begin
        req_t rq;
        bw_t  bw;
        forever begin
            @(negedge clk); #1;
            if (rst) begin
                if (mem_req) begin
                    if (exp_req.size() == 0) begin
                        chk("req_unexpected_addr", 64'(mem_addr), 64'hFFFF_FFFF_FFFF_FFFF);
                    end else begin
                        rq = exp_req[0];
                        chk("mem_addr", 64'(mem_addr), 64'(rq.addr));
                        chk("mem_we", 64'(mem_we), 64'(rq.we));
                        if (rq.we) chk("mem_wdata", 64'(mem_wdata), 64'(rq.wdata));
                        if (mem_gnt) begin
                            void'(exp_req.pop_front());
                            seen_addr.push_back(mem_addr);
                            seen_wdata.push_back(mem_wdata);
                        end
                    end
                end
                if (buf_wr_en) begin
                    buf_cnt++;
                    if (exp_buf.size() == 0) begin
                        chk("buf_unexpected_addr", 64'(buf_addr), 64'hFFFF_FFFF_FFFF_FFFF);
                    end else begin
                        bw = exp_buf.pop_front();
                        chk("buf_sel", 64'(buf_sel), 64'(bw.sel));
                        chk("buf_addr", 64'(buf_addr), 64'(bw.addr));
                        chk("buf_wdata", 64'(buf_wdata), 64'(bw.data));
                    end
                end
                if (f_dma) begin
                    chk("f_dma_expected", 64'(f_pending), 64'd1);
                    last_lat = cyc + 1 - s_edge;
                    chk("f_latency", 64'(last_lat), 64'(exp_lat));
                    chk("req_left", 64'(exp_req.size()), 64'd0);
                    chk("buf_left", 64'(exp_buf.size()), 64'd0);
                    chk("inf_conv", inf_conv, pend_inf);
                    chk("cmd_info", cmd_info, m_info);
                    chk("cmd_err", 64'(cmd_err), 64'(m_err));
                    m_inf = pend_inf;
                    f_pending = 1'b0;
                    done_cnt++;
                end
            end
        end
    end

    initial begin
        int d0;
        rst = 1'b0; s_dma = 1'b0; dma_op = '0;
        dma_info1 = '0; dma_info2 = '0; dma_mem_info1 = '0; dma_mem_info2 = '0;
        repeat (3) @(posedge clk); #1;
        chk("rst_f_dma", 64'(f_dma), 64'd0);
        chk("rst_mem_req", 64'(mem_req), 64'd0);
        chk("rst_cmd_err", 64'(cmd_err), 64'd0);
        chk("rst_inf_conv", inf_conv, 64'd0);
        chk("rst_mem_addr", 64'(mem_addr), 64'd0);
        chk("rst_buf_wr_en", 64'(buf_wr_en), 64'd0);
        rst = 1'b1;
        spur_rv = 1'b1;
        repeat (3) @(posedge clk);

        issue(3'd0, 32'h11, 32'h22, 32'd0, 32'd0, 0);
        wait_done("op0");
        chk("op0_lat_lit", 64'(last_lat), 64'd6);
        chk("op0_inf_lit", inf_conv, 64'h0000_0240_0C08_1010);

        issue(3'd1, 32'hA1, 32'hA2, 32'd4, 32'd32, 0);
        wait_done("op1");
        chk("op1_lat_lit", 64'(last_lat), 64'd34);
        chk("op1_addr0_lit", 64'(seen_addr[0]), 64'h0001_0024);
        chk("op1_addr4_lit", 64'(seen_addr[4]), 64'h0001_0034);
        chk("op1_addr15_lit", 64'(seen_addr[15]), 64'h0001_0057);
        chk("op1_bufcnt_lit", 64'(buf_cnt), 64'd16);

        stall_addr = 32'h0003_0000 + 32'd16 + 32'h40 + 32'd2; stall_left = 3;
        issue(3'd3, 32'hB1, 32'hB2, 32'd16, 32'h40, 3);
        wait_done("op3");
        chk("op3_lat_lit", 64'(last_lat), 64'd21);
        chk("op3_bufcnt_lit", 64'(buf_cnt), 64'd8);

        issue(3'd5, 32'hC1, 32'hC2, 32'd5, 32'h100, 0);
        wait_done("op5");
        chk("op5_lat_lit", 64'(last_lat), 64'd14);
        chk("op5_addr2_lit", 64'(seen_addr[2]), 64'h0008_010D);
        chk("op5_data2_lit", 64'(seen_wdata[2]), 64'd102);
        chk("op5_addr3_lit", 64'(seen_addr[3]), 64'h0008_010E);

        issue(3'd7, 32'hD1, 32'hD2, 32'd0, 32'd0, 0);
        wait_done("op7");
        chk("op7_lat_lit", 64'(last_lat), 64'd1);
        chk("op7_no_req", 64'(seen_addr.size()), 64'd0);
        chk("op7_err_lit", 64'(cmd_err), 64'd1);

        issue(3'd2, 32'hE1, 32'hE2, 32'd3, 32'h20, 0);
        repeat (3) @(posedge clk); #1;
        dma_op = 3'd1; dma_info1 = 32'hFFFF_0001; dma_mem_info1 = 32'h999; s_dma = 1'b1;
        @(posedge clk); #1;
        s_dma = 1'b0;
        wait_done("op2");
        chk("op2_writes_lit", 64'(seen_addr.size()), 64'd8);
        chk("op2_bufcnt_lit", 64'(buf_cnt), 64'd8);
        chk("op2_err_held", 64'(cmd_err), 64'd1);

        // Reset in the middle of an input-tile load (beat 5: row 1, col 1).
        issue(3'd1, 32'hF1, 32'hF2, 32'd0, 32'd0, 0);
        for (int i = 0; i < 200 && !(mem_req && mem_addr == 32'h0001_0011); i++) @(negedge clk);
        chk("beat5_reached", 64'(mem_req && mem_addr == 32'h0001_0011), 64'd1);
        #2 rst = 1'b0;
        #1;
        chk("mid_rst_mem_req", 64'(mem_req), 64'd0);
        chk("mid_rst_mem_addr", 64'(mem_addr), 64'd0);
        chk("mid_rst_buf_wr_en", 64'(buf_wr_en), 64'd0);
        chk("mid_rst_inf_conv", inf_conv, 64'd0);
        chk("mid_rst_cmd_err", 64'(cmd_err), 64'd0);
        chk("mid_rst_cmd_info", cmd_info, 64'd0);
        chk("mid_rst_obuf", 64'({obuf_rd_en, obuf_addr, buf_sel, buf_addr}), 64'd0);
        exp_req.delete(); exp_buf.delete();
        f_pending = 1'b0; m_inf = '0; pend_inf = '0; m_err = 1'b0;
        d0 = done_cnt;
        repeat (2) @(posedge clk); #1;
        rst = 1'b1;
        repeat (12) @(posedge clk); #1;
        chk("mid_rst_no_f_dma", 64'(done_cnt), 64'(d0));

        issue(3'd0, 32'h31, 32'h32, 32'd0, 32'd0, 0);
        wait_done("op0_after_rst");
        chk("op0b_inf_lit", inf_conv, 64'h0000_0240_0C08_1010);
        chk("op0b_lat_lit", 64'(last_lat), 64'd6);

        repeat (3) @(posedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
